// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//    Memory-side responder for the datapath's Read / ramWE strobes. It holds a
//    synchronous word RAM and serves one access per request. Each access waits
//    WAIT_CYCLES wait states, then performs the RAM access, then pulses done for
//    one cycle. The control sequencer stalls on that done pulse.
//
// Ports
//    clk    in   system clock, rising edge
//    rst    in   asynchronous active-high reset
//    Read   in   read request strobe
//    ramWE  in   write request strobe
//    addr   in   word address (MAR), wraps modulo 2^ADDR_W
//    wdata  in   write data (MDR)
//    rdata  out  last read word; changes only when a read access completes
//    done   out  one-cycle completion pulse for reads and writes
//    busy   out  high while a request is in flight (WAIT, ACCESS, DONE)
//    err    out  one-cycle pulse when Read and ramWE are both requested
//
// State table
//    state     | meaning
//    ST_IDLE   | waiting for a request strobe
//    ST_WAIT   | counting wait states down to zero
//    ST_ACCESS | RAM access happens on the exit edge of this state
//    ST_DONE   | done pulse cycle; a new request may be sampled on its exit edge

module mem_bus_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Read,
   input  logic              ramWE,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // The counter is preloaded with WAIT_CYCLES-1 so that WAIT lasts exactly
   // WAIT_CYCLES cycles; with zero wait states WAIT is skipped entirely.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                done_q;
   logic                busy_q;
   logic                err_q;

   logic [DATA_W-1:0]   mem_q [0:(1<<ADDR_W)-1];

   logic                req_one;
   logic                req_both;
   logic                mem_we;

   assign req_one  = Read ^ ramWE;
   assign req_both = Read & ramWE;
   assign mem_we   = (state_q == ST_ACCESS) && we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            // DONE shares the request sampling of IDLE so that a strobe held
            // across DONE starts the next access with no idle gap.
            ST_IDLE, ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (req_one) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  we_q    <= ramWE;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ST_ACCESS;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end
               end else if (req_both) begin
                  err_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_ACCESS;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_ACCESS: begin
               if (!we_q) begin
                  rdata_q <= mem_q[addr_q];
               end
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // RAM contents survive reset; an aborted write never reaches here because
   // the reset forces the FSM out of ACCESS before its exit edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign rdata = rdata_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule
